// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter onto a single shared memory port.
// Optional ARB_ROUND_ROBIN_EN: ties alternate via last_grant; otherwise requester 0 wins ties.
module mem_port_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] addr0,
   input  logic [WIDTH-1:0] addr1,
   input  logic [WIDTH-1:0] wdata0,
   input  logic [WIDTH-1:0] wdata1,
   input  logic             we0,
   input  logic             we1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] rdata,
   output logic             sel,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ready,
   input  logic [WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t state, state_next;
   logic   sel_next;
   logic   elig0, elig1;
   logic   tie_pick;
   logic   xfer_end;
   logic   load_rdata;

   // A requester whose done pulse is showing is still holding req for the
   // transfer that just ended, so it must sit out this arbitration.
   assign elig0 = req0 & ~done0;
   assign elig1 = req1 & ~done1;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant;

   assign tie_pick = ~last_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (state == IDLE && state_next != IDLE) begin
         last_grant <= (state_next == GRANT1);
      end
   end
`else
   assign tie_pick = 1'b0;
`endif

   always_comb begin
      state_next = state;
      sel_next   = sel;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      mem_req    = 1'b0;
      case (state)
         IDLE: begin
            if (elig0 && elig1) begin
               state_next = tie_pick ? GRANT1 : GRANT0;
               sel_next   = tie_pick;
            end else if (elig0) begin
               state_next = GRANT0;
               sel_next   = 1'b0;
            end else if (elig1) begin
               state_next = GRANT1;
               sel_next   = 1'b1;
            end
         end
         GRANT0: begin
            gnt0    = 1'b1;
            mem_req = 1'b1;
            if (mem_ready) begin
               state_next = IDLE;
            end
         end
         GRANT1: begin
            gnt1    = 1'b1;
            mem_req = 1'b1;
            if (mem_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Shared datapath mux; sel is registered so it holds through IDLE.
   assign mem_addr  = sel ? addr1  : addr0;
   assign mem_wdata = sel ? wdata1 : wdata0;
   assign mem_we    = mem_req & (sel ? we1 : we0);

   assign xfer_end   = mem_req & mem_ready;
   assign load_rdata = xfer_end & ~mem_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sel   <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         rdata <= '0;
      end else begin
         state <= state_next;
         sel   <= sel_next;
         done0 <= xfer_end & (state == GRANT0);
         done1 <= xfer_end & (state == GRANT1);
         if (load_rdata) begin
            rdata <= mem_rdata;
         end
      end
   end

endmodule
